regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write_enable / write_addr / write_data) between NREQ writeback requesters, e.g. ALU result, memory load, stack/interrupt restore.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Outputs come from a registered stage: the register file samples them on the following negedge.
- Sits between pipeline writeback sources and regfile.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*ADDR_W  packed destination register; requester i in bits [i*ADDR_W +: ADDR_W]
- req_data  input  NREQ*DATA_W  packed write data; requester i in bits [i*DATA_W +: DATA_W]
- req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- flush  input  1  synchronous drop of the pending output write
- rf_we  output  1  to regfile write_enable
- rf_waddr  output  ADDR_W  to regfile write_addr
- rf_wdata  output  DATA_W  to regfile write_data
- grant_id  output  3  index of requester whose write is on rf_* this cycle
- busy  output  1  rf_we asserted (write in flight)

Behaviour:
- Reset (rst=0, async):
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0.
  - Round-robin pointer ptr=0; req_ready=0 while reset is asserted.
- req_ready is combinational:
  - Exactly one bit is set, for the first valid requester scanning ptr, ptr+1, ... mod NREQ.
  - All zero if no req_valid.
  - Never asserted to a non-valid requester.
- Accept at posedge when any req_valid=1 and rst=1:
  - rf_we<=1; rf_waddr/rf_wdata <= winner's addr/data; grant_id <= winner.
  - ptr <= (winner+1) mod NREQ.
  - Latency: handshake in cycle N, rf_* valid in cycle N+1, regfile captures at the negedge of cycle N+1.
- No valid requester: rf_we<=0; rf_waddr/rf_wdata/grant_id hold last value; ptr unchanged.
- Throughput: one write per cycle, back-to-back; no bubble between consecutive grants.
- Fairness: a continuously-valid requester is granted within NREQ cycles; ptr only moves on a grant.
- Requester rule: addr/data stable and valid held until ready. Dropping valid before ready is legal (request withdrawn).
- Same destination address from several requesters: writes are serialized in grant order; the last one granted wins in the register file. No merging.
- flush=1 at a posedge:
  - rf_we<=0 and no request is accepted that cycle (req_ready forced 0).
  - ptr unchanged.
  - flush has priority over accept.
- Reset mid-operation: in-flight write is discarded immediately (rf_we drops asynchronously); pending requests are not acknowledged.
- NREQ=1: degenerates to a registered pass-through; ptr stays 0.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (NREQ*16): per-requester 16-bit saturating grant counters, incremented on each accepted transfer. Held at 16'hFFFF once saturated.
  - Adds input stat_clr (1): synchronous clear of all counters. stat_clr wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: the ports and counters do not exist; arbitration behaviour is identical.

Decomposition:
- Shared package regfile_pkg:
  - RF_DATA_W=16, RF_ADDR_W=3, RF_NREGS=8 constants.
  - WB_NREQ=3 default.
  - Requester index enum: WB_ALU=0, WB_MEM=1, WB_STK=2.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, ptr.
  - Outputs: one-hot gnt, encoded winner index, any_gnt.
  - Purely combinational; the pointer register stays in regfile_wb_arbiter.

Test Plan:
- Reset: rst=0 with req_valid=3'b111 -> req_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0. Release rst -> first grant to requester 0, next cycle rf_we=1.
- Single requester: req_valid=3'b010, addr=5, data=16'hBEEF -> req_ready=3'b010 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF, grant_id=1; regfile reg[5]=BEEF after negedge.
- Round-robin: all three valid continuously for 6 cycles from ptr=0 -> grant order 0,1,2,0,1,2, rf_we=1 every cycle after the first.
- Same address: req0 addr=2 data=1111 and req2 addr=2 data=2222, both valid, ptr=0 -> writes 1111 then 2222; reg[2]=2222 finally.
- Flush/reset mid-operation:
  - flush=1 while req1 valid -> req_ready=0, rf_we=0 next cycle, req1 granted the cycle after flush drops.
  - Async rst=0 mid-write -> rf_we falls immediately.
- WB_ARB_STATS_EN: 70000 grants to req0 -> stat_grants[0]=16'hFFFF. stat_clr together with a grant -> counter reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register file and its writeback
// arbiter.
//   RF_DATA_W / RF_ADDR_W / RF_NREGS : register file geometry
//   WB_NREQ                          : default number of writeback requesters
//   wb_req_e                         : requester index names
//   rr_next()                        : round-robin pointer advance with wrap
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREGS  = 8;

  localparam int WB_NREQ   = 3;

  // Width of the per-requester grant counters (optional statistics).
  localparam int WB_STAT_W = 16;

  typedef enum logic [2:0] {
    WB_ALU = 3'd0,
    WB_MEM = 3'd1,
    WB_STK = 3'd2
  } wb_req_e;

  // Pointer value that follows the winner 'idx' in a ring of 'n' entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Scans req starting at ptr and
// wrapping modulo N; the first set bit wins.
// Parameters:
//   N  : number of requesters
//   PW : width of ptr / winner
// Ports:
//   req     in  [N-1:0]  request vector
//   ptr     in  [PW-1:0] highest-priority index this cycle (must be < N)
//   gnt     out [N-1:0]  one-hot grant, zero when no request
//   winner  out [PW-1:0] encoded index of the granted requester (0 if none)
//   any_gnt out          some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner,
  output logic          any_gnt
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    winner  = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Position k steps after ptr, folded back into 0..N-1.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        winner   = PW'(idx);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between NREQ writeback
// requesters with round-robin arbitration and a valid/ready handshake.
// The winning request is registered onto rf_* one cycle after the
// handshake; the register file samples it on the following negedge.
//
// Parameters: NREQ (2..8, 1 allowed as a pass-through), DATA_W, ADDR_W.
// Ports:
//   clk          in   system clock, posedge
//   rst          in   asynchronous active-low reset
//   req_valid    in   [NREQ]          per-requester write request
//   req_addr     in   [NREQ*ADDR_W]   requester i at [i*ADDR_W +: ADDR_W]
//   req_data     in   [NREQ*DATA_W]   requester i at [i*DATA_W +: DATA_W]
//   req_ready    out  [NREQ]          combinational one-hot grant
//   flush        in   drop the pending write, accept nothing this cycle
//   rf_we/rf_waddr/rf_wdata  out      register file write port
//   grant_id     out  [3]             requester whose write is on rf_*
//   busy         out  rf_we asserted
// Optional (macro WB_ARB_STATS_EN):
//   stat_clr     in   synchronous clear of the grant counters
//   stat_grants  out  [NREQ*16]       saturating per-requester grant counts
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = WB_NREQ,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   flush,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [2:0]             grant_id,
`ifdef WB_ARB_STATS_EN
  input  logic                   stat_clr,
  output logic [NREQ*WB_STAT_W-1:0] stat_grants,
`endif
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     winner;
  logic [NREQ-1:0]   gnt;
  logic              any_gnt;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [PW-1:0]     ptr_next;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .winner  (winner),
    .any_gnt (any_gnt)
  );

  // Nothing is acknowledged while in reset or during a flush, so a
  // requester never sees a handshake that the write stage will drop.
  assign req_ready = (rst && !flush) ? gnt : '0;
  assign accept    = rst && !flush && any_gnt;

  // One-hot AND-OR select of the winner's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = PW'(rr_next(int'(winner), NREQ));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= 3'd0;
      ptr_reg  <= '0;
    end else if (accept) begin
      rf_we    <= 1'b1;
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      grant_id <= 3'(winner);
      ptr_reg  <= ptr_next;
    end else begin
      // Idle or flushed: retire the write, keep address/data/id/pointer.
      rf_we <= 1'b0;
    end
  end

  assign busy = rf_we;

`ifdef WB_ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stat
      logic [WB_STAT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (stat_clr) begin
          cnt_reg <= '0;
        end else if (req_valid[gi] && req_ready[gi] && !(&cnt_reg)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign stat_grants[gi*WB_STAT_W +: WB_STAT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter (NREQ=3, DATA_W=16, ADDR_W=3).
// A small register-file model captures rf_* on every negedge with rf_we=1.
// Build with +define+WB_ARB_STATS_EN to also exercise the grant counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   flush;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [2:0]             grant_id;
  logic                   busy;
`ifdef WB_ARB_STATS_EN
  logic                   stat_clr;
  logic [NREQ*16-1:0]     stat_grants;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] rf_model [8];

  regfile_wb_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
`ifdef WB_ARB_STATS_EN
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: samples the write port on the negedge.
  always @(negedge clk) begin
    if (rf_we) rf_model[rf_waddr] <= rf_wdata;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to just after the next posedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
`ifdef WB_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    flush     = 1'b0;
`ifdef WB_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    req_valid = 3'b111;
    req_addr  = {3'd6, 3'd5, 3'd4};
    req_data  = {16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 8; i++) rf_model[i] = '0;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 3'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", rf_wdata); end
    checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    cyc();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_hold_we got=%b exp=0", rf_we); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL reset_first_ready got=%b exp=001", req_ready); end
    cyc();
    checks++; if (rf_we !== 1'b1 || grant_id !== 3'd0 || rf_wdata !== 16'h1111 || rf_waddr !== 3'd4) begin
      failures++; $display("FAIL reset_first_write got we=%b gid=%0d addr=%0d data=%h exp we=1 gid=0 addr=4 data=1111", rf_we, grant_id, rf_waddr, rf_wdata);
    end
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL reset_next_ready got=%b exp=010", req_ready); end
    $display("test_reset done");
    req_valid = '0;
  endtask

  task automatic test_single();
    cyc();
    do_reset();
    req_valid = 3'b010;
    req_addr  = {3'd0, 3'd5, 3'd0};
    req_data  = {16'h0, 16'hBEEF, 16'h0};
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    cyc();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_we got we=%b busy=%b exp 1/1", rf_we, busy); end
    checks++; if (rf_waddr !== 3'd5) begin failures++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 16'hBEEF) begin failures++; $display("FAIL single_wdata got=%h exp=beef", rf_wdata); end
    checks++; if (grant_id !== 3'd1) begin failures++; $display("FAIL single_gid got=%0d exp=1", grant_id); end
    @(negedge clk); #1;
    checks++; if (rf_model[5] !== 16'hBEEF) begin failures++; $display("FAIL single_regfile got=%h exp=beef", rf_model[5]); end
    cyc();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 3'd5 || rf_wdata !== 16'hBEEF || grant_id !== 3'd1) begin
      failures++; $display("FAIL single_idle_hold got we=%b addr=%0d data=%h gid=%0d exp we=0 addr=5 data=beef gid=1", rf_we, rf_waddr, rf_wdata, grant_id);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_data [3];
    int e;
    exp_data[0] = 16'hA000; exp_data[1] = 16'hA001; exp_data[2] = 16'hA002;
    cyc();
    do_reset();
    req_addr  = {3'd3, 3'd2, 3'd1};
    req_data  = {16'hA002, 16'hA001, 16'hA000};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      e = k % 3;
      #1;
      checks++; if (req_ready !== 3'(1 << e)) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 3'(1 << e)); end
      cyc();
      checks++; if (rf_we !== 1'b1 || grant_id !== 3'(e) || rf_wdata !== exp_data[e]) begin
        failures++; $display("FAIL rr_write[%0d] got we=%b gid=%0d data=%h exp we=1 gid=%0d data=%h", k, rf_we, grant_id, rf_wdata, e, exp_data[e]);
      end
    end
    req_valid = '0;
    $display("test_round_robin done");
  endtask

  task automatic test_same_addr();
    cyc();
    do_reset();
    req_addr  = {3'd2, 3'd0, 3'd2};
    req_data  = {16'h2222, 16'h0000, 16'h1111};
    req_valid = 3'b101;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL same_ready0 got=%b exp=001", req_ready); end
    cyc();
    req_valid = 3'b100;
    checks++; if (rf_wdata !== 16'h1111 || rf_waddr !== 3'd2) begin failures++; $display("FAIL same_first got addr=%0d data=%h exp addr=2 data=1111", rf_waddr, rf_wdata); end
    @(negedge clk); #1;
    checks++; if (rf_model[2] !== 16'h1111) begin failures++; $display("FAIL same_reg_mid got=%h exp=1111", rf_model[2]); end
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL same_ready2 got=%b exp=100", req_ready); end
    cyc();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 16'h2222 || grant_id !== 3'd2) begin
      failures++; $display("FAIL same_second got we=%b data=%h gid=%0d exp we=1 data=2222 gid=2", rf_we, rf_wdata, grant_id);
    end
    @(negedge clk); #1;
    checks++; if (rf_model[2] !== 16'h2222) begin failures++; $display("FAIL same_reg_final got=%h exp=2222", rf_model[2]); end
    $display("test_same_addr done");
  endtask

  task automatic test_flush();
    cyc();
    do_reset();
    req_addr  = {3'd0, 3'd7, 3'd0};
    req_data  = {16'h0, 16'h5A5A, 16'h0};
    req_valid = 3'b010;
    cyc();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL flush_pre_we got=%b exp=1", rf_we); end
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
    cyc();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", rf_we); end
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL flush_after_ready got=%b exp=010", req_ready); end
    cyc();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1 || grant_id !== 3'd1) begin failures++; $display("FAIL flush_after_grant got we=%b gid=%0d exp we=1 gid=1", rf_we, grant_id); end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    cyc();
    do_reset();
    req_addr  = {3'd0, 3'd0, 3'd3};
    req_data  = {16'h0, 16'h0, 16'hC0DE};
    req_valid = 3'b001;
    cyc();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL arst_pre_we got=%b exp=1", rf_we); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arst_we got we=%b busy=%b exp 0/0", rf_we, busy); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL arst_ready got=%b exp=000", req_ready); end
    req_valid = 3'b000;
    rst = 1'b1;
    $display("test_async_reset done");
  endtask

  // Pointer must stay put across idle cycles and only move on a grant.
  task automatic test_ptr_hold();
    cyc();
    do_reset();
    req_addr  = {3'd1, 3'd1, 3'd1};
    req_data  = {16'h0003, 16'h0002, 16'h0001};
    req_valid = 3'b010;
    cyc();
    req_valid = 3'b000;
    cyc();
    cyc();
    cyc();
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL ptr_hold_ready got=%b exp=100", req_ready); end
    cyc();
    checks++; if (grant_id !== 3'd2 || rf_wdata !== 16'h0003) begin failures++; $display("FAIL ptr_hold_grant got gid=%0d data=%h exp gid=2 data=0003", grant_id, rf_wdata); end
    // Withdrawn request: requester 0 drops valid, requester 1 must win.
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL withdraw_ready got=%b exp=010", req_ready); end
    req_valid = 3'b000;
    $display("test_ptr_hold done");
  endtask

`ifdef WB_ARB_STATS_EN
  task automatic test_stats();
    cyc();
    do_reset();
    #1;
    checks++; if (stat_grants !== '0) begin failures++; $display("FAIL stats_reset got=%h exp=0", stat_grants); end
    req_addr  = {3'd0, 3'd0, 3'd1};
    req_data  = {16'h0, 16'h0, 16'h7777};
    req_valid = 3'b001;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    req_valid = 3'b000;
    checks++; if (stat_grants[15:0] !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h exp=ffff", stat_grants[15:0]); end
    checks++; if (stat_grants[47:16] !== 32'h0) begin failures++; $display("FAIL stats_others got=%h exp=0", stat_grants[47:16]); end
    req_valid = 3'b001;
    stat_clr  = 1'b1;
    cyc();
    stat_clr  = 1'b0;
    req_valid = 3'b000;
    checks++; if (stat_grants[15:0] !== 16'h0) begin failures++; $display("FAIL stats_clr got=%h exp=0000", stat_grants[15:0]); end
    req_valid = 3'b100;
    cyc();
    req_valid = 3'b000;
    checks++; if (stat_grants[47:32] !== 16'd1) begin failures++; $display("FAIL stats_inc got=%h exp=0001", stat_grants[47:32]); end
    $display("test_stats done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_addr();
    test_flush();
    test_async_reset();
    test_ptr_hold();
`ifdef WB_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
